// File: rtl/rib_mailbox_pkg.sv
// Shared register map, STATUS layout and word type for the RIB inter-core mailbox.
package rib_mailbox_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] MBOX_A2B_DATA = 8'h00;
  localparam logic [7:0] MBOX_A2B_POP  = 8'h04;
  localparam logic [7:0] MBOX_B2A_DATA = 8'h08;
  localparam logic [7:0] MBOX_B2A_POP  = 8'h0C;
  localparam logic [7:0] MBOX_STATUS   = 8'h10;
  localparam logic [7:0] MBOX_INT_EN   = 8'h14;
  localparam logic [7:0] MBOX_ERR      = 8'h18;

  localparam int unsigned ST_B2A_CNT_LSB = 8;
  localparam int unsigned ST_A2B_EMPTY   = 16;
  localparam int unsigned ST_A2B_FULL    = 17;
  localparam int unsigned ST_B2A_EMPTY   = 18;
  localparam int unsigned ST_B2A_FULL    = 19;

  typedef struct packed {
    logic [7:0] cnt;
    logic       empty;
    logic       full;
  } fifo_stat_t;

  function automatic word_t mbox_status(input fifo_stat_t a2b, input fifo_stat_t b2a);
    word_t s;
    s = '0;
    s[7:0]                          = a2b.cnt;
    s[ST_B2A_CNT_LSB +: 8]          = b2a.cnt;
    s[ST_A2B_EMPTY]                 = a2b.empty;
    s[ST_A2B_FULL]                  = a2b.full;
    s[ST_B2A_EMPTY]                 = b2a.empty;
    s[ST_B2A_FULL]                  = b2a.full;
    return s;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Single-clock word FIFO for the mailbox: registered pointers/count, combinational
// head/empty/full, and one-cycle overflow/underflow indications.
module mbox_fifo
  import rib_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  word_t            i_data,
  output word_t            o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_ovf,
  output logic             o_udf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  word_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_ovf     = i_push & o_full;
  assign o_udf     = i_pop & o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rib_mailbox.sv
// RIB slave mailbox with A2B/B2A FIFOs and per-core level interrupts.
// Optional sticky error register at 0x18 when MBOX_ERR_EN is defined.
module rib_mailbox
  import rib_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_a_o,
  output logic        int_b_o
);

  logic [7:0]       w_off;
  logic             w_wr;
  logic             w_a2b_push, w_a2b_pop, w_b2a_push, w_b2a_pop;
  word_t            w_a2b_head, w_b2a_head;
  logic [CNT_W-1:0] w_a2b_cnt, w_b2a_cnt;
  logic             w_a2b_empty, w_a2b_full, w_b2a_empty, w_b2a_full;
  logic             w_a2b_ovf, w_a2b_udf, w_b2a_ovf, w_b2a_udf;
  word_t            w_err_rd;
  logic [1:0]       r_int_en;
  logic             r_int_a;
  logic             r_int_b;
  logic             w_unused_addr;

  assign w_off         = addr_i[7:0];
  assign w_unused_addr = ^addr_i[31:8];
  assign w_wr          = we_i & rst;
  assign w_a2b_push    = w_wr & (w_off == MBOX_A2B_DATA);
  assign w_a2b_pop     = w_wr & (w_off == MBOX_A2B_POP);
  assign w_b2a_push    = w_wr & (w_off == MBOX_B2A_DATA);
  assign w_b2a_pop     = w_wr & (w_off == MBOX_B2A_POP);

  mbox_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_a2b (
    .clk(clk), .rst(rst), .i_push(w_a2b_push), .i_pop(w_a2b_pop), .i_data(data_i),
    .o_head(w_a2b_head), .o_count(w_a2b_cnt), .o_empty(w_a2b_empty), .o_full(w_a2b_full),
    .o_ovf(w_a2b_ovf), .o_udf(w_a2b_udf)
  );

  mbox_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_b2a (
    .clk(clk), .rst(rst), .i_push(w_b2a_push), .i_pop(w_b2a_pop), .i_data(data_i),
    .o_head(w_b2a_head), .o_count(w_b2a_cnt), .o_empty(w_b2a_empty), .o_full(w_b2a_full),
    .o_ovf(w_b2a_ovf), .o_udf(w_b2a_udf)
  );

  // Interrupts use the pre-edge enable and occupancy, so they lag the access by one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_int_en <= '0;
      r_int_a  <= 1'b0;
      r_int_b  <= 1'b0;
    end else begin
      if (w_wr && (w_off == MBOX_INT_EN)) r_int_en <= data_i[1:0];
      r_int_b <= r_int_en[0] & ~w_a2b_empty;
      r_int_a <= r_int_en[1] & ~w_b2a_empty;
    end
  end

  assign int_a_o = r_int_a;
  assign int_b_o = r_int_b;

`ifdef MBOX_ERR_EN
  logic [3:0] r_err;
  logic [3:0] w_err_set;
  logic [3:0] w_err_clr;

  assign w_err_set = {w_b2a_udf, w_b2a_ovf, w_a2b_udf, w_a2b_ovf};
  assign w_err_clr = (w_wr && (w_off == MBOX_ERR)) ? data_i[3:0] : 4'b0000;
  assign w_err_rd  = {28'd0, r_err};

  always_ff @(posedge clk) begin
    if (!rst) r_err <= '0;
    else      r_err <= (r_err & ~w_err_clr) | w_err_set;
  end
`else
  logic w_unused_err;
  assign w_unused_err = w_a2b_ovf ^ w_a2b_udf ^ w_b2a_ovf ^ w_b2a_udf;
  assign w_err_rd     = '0;
`endif

  always_comb begin
    data_o = '0;
    case (w_off)
      MBOX_A2B_DATA: data_o = w_a2b_head;
      MBOX_B2A_DATA: data_o = w_b2a_head;
      MBOX_STATUS:   data_o = mbox_status('{cnt: 8'(w_a2b_cnt), empty: w_a2b_empty, full: w_a2b_full},
                                          '{cnt: 8'(w_b2a_cnt), empty: w_b2a_empty, full: w_b2a_full});
      MBOX_INT_EN:   data_o = {30'd0, r_int_en};
      MBOX_ERR:      data_o = w_err_rd;
      default:       data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_rib_mailbox.sv
// Self-checking bench for rib_mailbox: constant vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rib_mailbox;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        int_a_o;
  logic        int_b_o;

  rib_mailbox #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .int_a_o(int_a_o), .int_b_o(int_b_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: message queues plus architectural registers.
  logic [31:0] mq_a[$];
  logic [31:0] mq_b[$];
  logic [1:0]  m_en;
  logic [3:0]  m_err;
  logic        m_ia, m_ib;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int s;
    case (a)
      8'h00: return (mq_a.size() != 0) ? mq_a[0] : 32'd0;
      8'h08: return (mq_b.size() != 0) ? mq_b[0] : 32'd0;
      8'h10: begin
        s = mq_a.size() + mq_b.size() * 256
          + ((mq_a.size() == 0) ? 65536 : 0) + ((mq_a.size() == DEPTH) ? 131072 : 0)
          + ((mq_b.size() == 0) ? 262144 : 0) + ((mq_b.size() == DEPTH) ? 524288 : 0);
        return 32'(s);
      end
      8'h14: return {30'd0, m_en};
`ifdef MBOX_ERR_EN
      8'h18: return {28'd0, m_err};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    mq_a.delete();
    mq_b.delete();
    m_en = 2'b00;
    m_err = 4'h0;
    m_ia = 1'b0;
    m_ib = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] a, input logic [31:0] d);
    m_ib = m_en[0] && (mq_a.size() != 0);
    m_ia = m_en[1] && (mq_b.size() != 0);
    if (we) begin
      case (a)
        8'h00: if (mq_a.size() < DEPTH) mq_a.push_back(d); else m_err[0] = 1'b1;
        8'h04: if (mq_a.size() != 0) void'(mq_a.pop_front()); else m_err[1] = 1'b1;
        8'h08: if (mq_b.size() < DEPTH) mq_b.push_back(d); else m_err[2] = 1'b1;
        8'h0C: if (mq_b.size() != 0) void'(mq_b.pop_front()); else m_err[3] = 1'b1;
        8'h14: m_en = d[1:0];
        8'h18: m_err = m_err & ~d[3:0];
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic we, input logic [7:0] a, input logic [31:0] d);
    we_i = we;
    addr_i = {24'd0, a};
    data_i = d;
    @(posedge clk);
    model_edge(we, a, d);
    #1;
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    we_i = 1'b0;
    addr_i = {24'd0, a};
    #1;
    v = data_o;
  endtask

  task automatic pulse_reset(input int cycles);
    rst = 1'b0;
    we_i = 1'b0;
    repeat (cycles) @(posedge clk);
    model_clear();
    #1;
    rst = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    logic [7:0] regs [5];
    regs = '{8'h00, 8'h08, 8'h10, 8'h14, 8'h18};
    foreach (regs[i]) begin
      rd(regs[i], v);
      chk($sformatf("%s rd%02h", tag, regs[i]), v, model_read(regs[i]));
    end
    chk({tag, " int_a"}, {31'd0, int_a_o}, {31'd0, m_ia});
    chk({tag, " int_b"}, {31'd0, int_b_o}, {31'd0, m_ib});
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] exp;
    logic        exp_ia;
    logic        exp_ib;
  } vec_t;

  vec_t vt[5];
  int   exp_order[8];

  initial begin
    logic [31:0] v;
    int r;

    rst = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    model_clear();

    vt[0] = '{1'b1, 8'h14, 32'h1,        8'h14, 32'h0000_0001, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h00, 32'hDEADBEEF, 8'h00, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[2] = '{1'b0, 8'h00, 32'h0,        8'h10, 32'h0004_0001, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'h04, 32'h0,        8'h10, 32'h0005_0000, 1'b0, 1'b1};
    vt[4] = '{1'b0, 8'h00, 32'h0,        8'h00, 32'h0000_0000, 1'b0, 1'b0};
    exp_order = '{4, 5, 6, 7, 8, 10, 11, 12};

    // Reset
    pulse_reset(2);
    rd(8'h10, v); chk("reset status", v, 32'h0005_0000);
    rd(8'h00, v); chk("reset a2b data", v, 32'h0);
    rd(8'h08, v); chk("reset b2a data", v, 32'h0);
    chk("reset int_a", {31'd0, int_a_o}, 32'h0);
    chk("reset int_b", {31'd0, int_b_o}, 32'h0);

    // Push and interrupt table
    foreach (vt[i]) begin
      do_op(vt[i].we, vt[i].addr, vt[i].wdata);
      rd(vt[i].raddr, v);
      chk($sformatf("vec%0d rd", i), v, vt[i].exp);
      chk($sformatf("vec%0d int_a", i), {31'd0, int_a_o}, {31'd0, vt[i].exp_ia});
      chk($sformatf("vec%0d int_b", i), {31'd0, int_b_o}, {31'd0, vt[i].exp_ib});
    end
    check_all("table");

    // Full and wrap on B2A
    for (int i = 1; i <= 8; i++) do_op(1'b1, 8'h08, 32'(i));
    rd(8'h10, v); chk("b2a full bit", {31'd0, v[19]}, 32'd1);
    do_op(1'b1, 8'h08, 32'd9);
    rd(8'h10, v); chk("b2a cnt after drop", {24'd0, v[15:8]}, 32'd8);
    rd(8'h08, v); chk("b2a head after drop", v, 32'd1);
    for (int i = 0; i < 3; i++) do_op(1'b1, 8'h0C, 32'h0);
    for (int i = 10; i <= 12; i++) do_op(1'b1, 8'h08, 32'(i));
    check_all("wrap");
    foreach (exp_order[i]) begin
      rd(8'h08, v);
      chk($sformatf("drain%0d", i), v, 32'(exp_order[i]));
      do_op(1'b1, 8'h0C, 32'h0);
    end
    rd(8'h10, v); chk("drained status", v, 32'h0005_0000);

    // Error flags
    do_op(1'b1, 8'h18, 32'hF);
    for (int i = 0; i < 9; i++) do_op(1'b1, 8'h08, 32'h100 + 32'(i));
    do_op(1'b1, 8'h04, 32'h0);
    rd(8'h18, v);
`ifdef MBOX_ERR_EN
    chk("err set", v, 32'h6);
    do_op(1'b1, 8'h18, 32'h6);
    rd(8'h18, v); chk("err cleared", v, 32'h0);
`else
    chk("err absent", v, 32'h0);
`endif
    check_all("err");

    // Independence: A2B pushes interleaved with B2A pops
    do_op(1'b1, 8'h14, 32'h3);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) do_op(1'b1, 8'h00, 32'hA000 + 32'(i));
      else            do_op(1'b1, 8'h0C, 32'h0);
      check_all($sformatf("indep%0d", i));
    end
    do_op(1'b0, 8'h00, 32'h0);
    chk("indep int_a", {31'd0, int_a_o}, 32'd1);
    chk("indep int_b", {31'd0, int_b_o}, 32'd1);

    // Mid-operation reset with 5 queued
    do_op(1'b1, 8'h00, 32'hBEEF);
    rd(8'h10, v); chk("pre-reset a2b cnt", {28'd0, v[3:0]}, 32'd5);
    pulse_reset(1);
    rd(8'h10, v); chk("mid reset status", v, 32'h0005_0000);
    rd(8'h00, v); chk("mid reset a2b data", v, 32'h0);
    rd(8'h08, v); chk("mid reset b2a data", v, 32'h0);
    chk("mid reset int_a", {31'd0, int_a_o}, 32'h0);
    chk("mid reset int_b", {31'd0, int_b_o}, 32'h0);
    check_all("mid reset");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      case (r)
        0, 1, 2: do_op(1'b1, 8'h00, $urandom);
        3, 4:    do_op(1'b1, 8'h04, $urandom);
        5, 6, 7: do_op(1'b1, 8'h08, $urandom);
        8:       do_op(1'b1, 8'h0C, $urandom);
        9:       do_op(1'b1, 8'h14, $urandom);
        10:      do_op(1'b1, ($urandom_range(0, 1) == 0) ? 8'h18 : 8'h1C, $urandom);
        default: do_op(1'b0, 8'h00, $urandom);
      endcase
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rib_mailbox.md
# rib_mailbox

Inter-core mailbox peripheral that sits as a responder (slave) on the RIB interconnect, serving requests issued by both tinyriscv cores. It holds two independent word FIFOs: A2B carries messages from core 0 to core 1, and B2A carries messages from core 1 to core 0. Each core receives a level interrupt when its inbound FIFO holds data. One interrupt output feeds the currently unused `int_flag_1` bit 0, and the other is ORed into `int_flag_0`.

## Interface
Parameters:
- `DEPTH`, default 8: entries per FIFO. Must be a power of two, ≥2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-low (`RstEnable` = 1'b0).
- `we_i`  in  1  write strobe from RIB; `WriteEnable` = 1.
- `addr_i`  in  `MemAddrBus` (32)  byte address. Only `addr_i[7:0]` is decoded; RIB handles the upper bits.
- `data_i`  in  `MemBus` (32)  write data.
- `data_o`  out  `MemBus` (32)  read data, combinational from `addr_i`.
- `int_a_o`  out  1  interrupt to core 0: B2A not empty and enabled.
- `int_b_o`  out  1  interrupt to core 1: A2B not empty and enabled.

## Operation
Register map (word offsets):
- 0x00 A2B_DATA. Write pushes `data_i` into A2B. Read returns the A2B head, or 0 if empty.
- 0x04 A2B_POP. Any write pops A2B. Reads 0.
- 0x08 B2A_DATA and 0x0C B2A_POP behave the same way for B2A.
- 0x10 STATUS (RO):
  - [CNT_W-1:0] A2B count
  - [15:8] B2A count
  - [16] A2B empty, [17] A2B full
  - [18] B2A empty, [19] B2A full
- 0x14 INT_EN (RW, 2 bits):
  - bit0 enables `int_b_o`
  - bit1 enables `int_a_o`
- 0x18 ERR: W1C sticky flags, present only with `MBOX_ERR_EN`.
- Unmapped offsets: reads return 0, writes are ignored.

Access rules:
- Reads never have side effects. RIB drives slave addresses continuously, so a pop requires an explicit write to the POP register.
- Push to a full FIFO: data dropped, pointers unchanged.
- Pop of an empty FIFO: ignored.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count ranges 0..DEPTH.
- The single port allows only one access per cycle, so push and pop of the same FIFO can never occur in the same cycle. The two FIFOs are independent.
- Interrupts are registered:
  - `int_b_o <= INT_EN[0] & (a2b_cnt != 0)`
  - `int_a_o <= INT_EN[1] & (b2a_cnt != 0)`

## Timing
- Reset (`rst`==0 at a `clk` edge) clears pointers, counts, INT_EN, ERR, `int_a_o` and `int_b_o`. Afterwards:
  - STATUS reads 0x0005_0000 (both FIFOs empty).
  - DATA registers read 0.
- FIFO storage is not reset.
- A reset asserted mid-operation discards all queued messages on that edge.
- Write to DATA at edge N: head and count are visible on `data_o` after edge N.
- Interrupt latency:
  - `int_*_o` rises at edge N+1 after the push at edge N.
  - It falls at edge N+1 after the pop at edge N that empties the FIFO.
- Read latency is 0 cycles (combinational), matching the rom/ram/timer slaves.

## Configuration
- Macro `MBOX_ERR_EN`.
  - Defined: ERR register at 0x18 with four sticky flags, set on the offending edge and cleared by writing 1 to the bit:
    - bit0 A2B overflow, bit1 A2B underflow
    - bit2 B2A overflow, bit3 B2A underflow
  - Undefined: no ERR flops. Offset 0x18 reads 0 and writes are ignored. Overflow and underflow still drop or ignore the access silently.

## Structure
- Register offsets and STATUS bit positions go in a shared header, `mbox_defines.v`, included alongside `defines.v`. The firmware header mirrors it.
- One sub-module, `mbox_fifo`: synchronous push/pop, registered pointers and count, combinational head/empty/full, and an overflow/underflow pulse. It is instantiated twice (A2B, B2A).

## Test plan
- Reset:
  - Hold `rst`=0 for 2 cycles.
  - Expect STATUS = 0x0005_0000, `int_a_o` = `int_b_o` = 0, and reads of 0x00/0x08 = 0.
- Push and interrupt:
  - INT_EN = 0x1, then push 0xDEADBEEF to A2B.
  - Expect the next-cycle read of 0x00 = 0xDEADBEEF and A2B count = 1.
  - Expect `int_b_o` = 1 one cycle after the push.
  - Pop: `int_b_o` = 0 one cycle later, empty bit = 1.
- Full and wrap:
  - Push 1..8 into B2A: full = 1.
  - Push 9 → dropped.
  - Pop 3, push 10,11,12, then drain.
  - Expect order 4,5,6,7,8,10,11,12 with pointers wrapped.
- Errors (`MBOX_ERR_EN`):
  - Overflow B2A and pop an empty A2B → ERR = 0x6.
  - Write 0x6 to ERR → ERR = 0.
  - Without the macro, ERR reads 0.
- Independence:
  - Interleave pushes to A2B and pops from B2A on alternating cycles.
  - Expect counts tracked independently; `int_a_o` is unaffected by A2B activity.
- Mid-operation reset: with 5 entries queued, pulse `rst`. Expect counts 0, interrupts 0, and DATA reads 0.
